// File: rtl/nreg_arb_pkg.sv
// Shared types and sizing helpers for the shared N-register arbiter.
package nreg_arb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam int unsigned NREQ_MAX    = 8;
    localparam int unsigned STATS_CNT_W = 8;

    // Index width for n requesters; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned IDX_W_MAX = idx_w(NREQ_MAX);

endpackage

// File: rtl/nreg_share_arbiter_if.sv
// Client-side bus of the shared N-register arbiter.
// Optional NREG_ARB_STATS_EN adds the per-requester grant count vector.
interface nreg_share_arbiter_if
    import nreg_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned NREG_W = 8
);
    localparam int unsigned IW = idx_w(NREQ);

    logic [NREQ-1:0]        io_req_valid;
    logic [NREQ-1:0]        io_req_lock;
    logic [NREQ*NREG_W-1:0] io_req_data;
    logic [NREQ-1:0]        io_req_ready;
    logic [NREG_W-1:0]      io_Q;
    logic                   io_Q_valid;
    logic                   io_wr_pulse;
    logic [IW-1:0]          io_owner;
    logic                   io_locked;
    logic                   io_lock_expired;
`ifdef NREG_ARB_STATS_EN
    logic [NREQ*STATS_CNT_W-1:0] io_grant_cnt;
`endif

    modport master (
        output io_req_valid, io_req_lock, io_req_data,
        input  io_req_ready,
`ifdef NREG_ARB_STATS_EN
        input  io_grant_cnt,
`endif
        input  io_Q, io_Q_valid, io_wr_pulse, io_owner, io_locked, io_lock_expired
    );

    modport slave (
        input  io_req_valid, io_req_lock, io_req_data,
        output io_req_ready,
`ifdef NREG_ARB_STATS_EN
        output io_grant_cnt,
`endif
        output io_Q, io_Q_valid, io_wr_pulse, io_owner, io_locked, io_lock_expired
    );

endinterface

// File: rtl/nreg_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module nreg_rr_picker
    import nreg_arb_pkg::*;
#(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nreg_share_arbiter.sv
// One NREG_W-bit register shared by NREQ writers with round-robin arbitration and timed locks.
// Define NREG_ARB_STATS_EN to add saturating per-requester grant counters (io_grant_cnt).
module nreg_share_arbiter
    import nreg_arb_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned NREG_W       = 8,
    parameter int unsigned LOCK_TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    nreg_share_arbiter_if.slave        bus
);

    localparam int unsigned IW = idx_w(NREQ);

    state_t            state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [7:0]        tmo_cnt;
    logic [NREG_W-1:0] q_reg;
    logic              q_valid;
    logic              wr_pulse;
    logic              lock_expired;

    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [NREQ-1:0]   ready;
    logic [IW-1:0]     hs_idx;
    logic              hs_any;
    logic [NREG_W-1:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = bus.io_req_data[g*NREG_W +: NREG_W];
    end

    nreg_rr_picker #(.NREQ(NREQ)) u_picker (
        .req       (bus.io_req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // While locked the picker is bypassed: only the owner can be granted.
    always_comb begin
        ready  = '0;
        hs_idx = owner;
        if (state == ST_IDLE) begin
            ready  = pick_grant;
            hs_idx = pick_idx;
        end else begin
            ready[owner] = bus.io_req_valid[owner];
        end
        hs_any = |(bus.io_req_valid & ready);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            owner        <= '0;
            tmo_cnt      <= '0;
            q_reg        <= '0;
            q_valid      <= 1'b0;
            wr_pulse     <= 1'b0;
            lock_expired <= 1'b0;
        end else begin
            wr_pulse     <= hs_any;
            lock_expired <= 1'b0;
            if (hs_any) begin
                q_reg   <= data_arr[hs_idx];
                q_valid <= 1'b1;
                owner   <= hs_idx;
                ptr     <= (hs_idx == IW'(NREQ - 1)) ? '0 : hs_idx + 1'b1;
                tmo_cnt <= '0;
                state   <= bus.io_req_lock[hs_idx] ? ST_LOCKED : ST_IDLE;
            end else if (state == ST_LOCKED) begin
                // No handshake while locked means the owner is idle this cycle.
                if (tmo_cnt == 8'(LOCK_TIMEOUT - 1)) begin
                    state        <= ST_IDLE;
                    tmo_cnt      <= '0;
                    lock_expired <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                end
            end
        end
    end

`ifdef NREG_ARB_STATS_EN
    logic [STATS_CNT_W-1:0] grant_cnt [NREQ];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                grant_cnt[i] <= '0;
            end
        end else if (hs_any && (grant_cnt[hs_idx] != '1)) begin
            grant_cnt[hs_idx] <= grant_cnt[hs_idx] + 1'b1;
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : g_stats
        assign bus.io_grant_cnt[g*STATS_CNT_W +: STATS_CNT_W] = grant_cnt[g];
    end
`endif

    assign bus.io_req_ready    = ready;
    assign bus.io_Q            = q_reg;
    assign bus.io_Q_valid      = q_valid;
    assign bus.io_wr_pulse     = wr_pulse;
    assign bus.io_owner        = owner;
    assign bus.io_locked       = (state == ST_LOCKED);
    assign bus.io_lock_expired = lock_expired;

endmodule
